i2c_temp_responder: RTL

- I2C target (responder) that emulates a 16-bit temperature sensor at a fixed 7-bit address; it is the far end of the controller that reads temperature over I2C.
- Oversamples raw SCL/SDA on the system clock, detects START/STOP, matches the address, ACKs, and returns the sampled temperature MSB-first.
- Accepts a one-byte pointer write. Used in simulation benches and in loopback on the board.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_bus_sync.sv | 57 +++++
 rtl/i2c_temp_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C temperature responder
//            and its bus front end.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Responder protocol states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDRESS    = 3'd1,
        ST_ADDR_ACK   = 3'd2,
        ST_READ_BYTE  = 3'd3,
        ST_MASTER_ACK = 3'd4,
        ST_WRITE_BYTE = 3'd5,
        ST_WRITE_ACK  = 3'd6,
        ST_IGNORE     = 3'd7
    } state_e;

    // Level of SDA during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Target address used when the instantiating level does not override it
    localparam logic [6:0] DEFAULT_ADDRESS = 7'h48;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Purpose  : Synchronises raw SCL/SDA to the system clock and derives
//            one-cycle SCL edge pulses plus START/STOP conditions.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchroniser chains plus one history flop per line; idle bus is high,
    // so reset to 1 to avoid phantom edges when reset is released
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SDA may only move while SCL is high for START/STOP; require SCL high
    // on both samples so an SDA change racing an SCL edge is not mistaken
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule : i2c_bus_sync
`default_nettype wire

// File: rtl/i2c_temp_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_temp_responder
// Purpose  : I2C target emulating a 16-bit temperature sensor. Returns the
//            temperature captured at the read-address ACK (MSB byte first,
//            alternating bytes on ACK) and accepts pointer-byte writes.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_temp_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = DEFAULT_ADDRESS,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    input  logic [15:0] temperature_i,
    output logic        sda_drive_low_o,
    output logic        busy_o,
    output logic [7:0]  pointer_o,
    output logic        read_done_o
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    state_e      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;        // bit position within the byte
    logic        done_q,      done_d;       // 8 bits shifted / ACK seen
    logic [7:0]  shift_q,     shift_d;
    logic [15:0] temp_q,      temp_d;
    logic        byte_idx_q,  byte_idx_d;   // 0 = MSB byte, 1 = LSB byte
    logic        drive_q,     drive_d;
    logic        busy_q,      busy_d;
    logic [7:0]  pointer_q,   pointer_d;
    logic        read_done_q, read_done_d;

    // Index of the next bit in the current byte and of the next byte's MSB
    logic [3:0]  next_bit_idx;
    logic [3:0]  next_msb_idx;
    assign next_bit_idx = {~byte_idx_q, cnt_q - 3'd1};
    assign next_msb_idx = {byte_idx_q, 3'd7};

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd7;
            done_q      <= 1'b0;
            shift_q     <= 8'h00;
            temp_q      <= 16'h0000;
            byte_idx_q  <= 1'b0;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
            pointer_q   <= 8'h00;
            read_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            shift_q     <= shift_d;
            temp_q      <= temp_d;
            byte_idx_q  <= byte_idx_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
            pointer_q   <= pointer_d;
            read_done_q <= read_done_d;
        end
    end

    // Protocol sequencing; bus conditions override any coincident SCL edge
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        shift_d     = shift_q;
        temp_d      = temp_q;
        byte_idx_d  = byte_idx_q;
        drive_d     = drive_q;
        busy_d      = busy_q;
        pointer_d   = pointer_q;
        read_done_d = 1'b0;

        if (bus_stop) begin
            state_d = ST_IDLE;
            drive_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (bus_start) begin
            state_d = ST_ADDRESS;
            cnt_d   = 3'd7;
            done_d  = 1'b0;
            drive_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDRESS: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (shift_q[7:1] == ADDRESS) begin
                            state_d = ST_ADDR_ACK;
                            drive_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            drive_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd7;
                        if (shift_q[0]) begin
                            temp_d     = temperature_i;
                            byte_idx_d = 1'b0;
                            drive_d    = ~temperature_i[15];
                            state_d    = ST_READ_BYTE;
                        end else begin
                            drive_d = 1'b0;
                            done_d  = 1'b0;
                            state_d = ST_WRITE_BYTE;
                        end
                    end
                end
                ST_READ_BYTE: begin
                    // Open-drain: a 1 is released, never driven high
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            drive_d = 1'b0;
                            done_d  = 1'b0;
                            state_d = ST_MASTER_ACK;
                        end else begin
                            cnt_d   = cnt_q - 3'd1;
                            drive_d = ~temp_q[next_bit_idx];
                        end
                    end
                end
                ST_MASTER_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            done_d = 1'b1;
                        end else begin
                            read_done_d = 1'b1;
                            state_d     = ST_IGNORE;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d     = 1'b0;
                        byte_idx_d = ~byte_idx_q;
                        cnt_d      = 3'd7;
                        drive_d    = ~temp_q[next_msb_idx];
                        state_d    = ST_READ_BYTE;
                    end
                end
                ST_WRITE_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            done_d = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        pointer_d = shift_q;
                        drive_d   = 1'b1;
                        state_d   = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        drive_d = 1'b0;
                        cnt_d   = 3'd7;
                        state_d = ST_WRITE_BYTE;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    drive_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

    // Release the bus combinationally when reset is asserted or a bus
    // condition is seen, so SDA is never held across either event
    assign sda_drive_low_o = drive_q & rst_ni & ~bus_start & ~bus_stop;
    assign busy_o          = busy_q;
    assign pointer_o       = pointer_q;
    assign read_done_o     = read_done_q;

endmodule : i2c_temp_responder
`default_nettype wire
